dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the pipelined CPU's MEM stage and the line-wide external data memory. It serves CPU word loads and stores from an internal tag/data array. On a miss it raises a stall to the CPU, writes back the victim line if it is dirty, and refills the line with a request/acknowledge handshake to memory.

## Interface
- `SETS`, 16: number of cache lines; the index is log2(SETS) bits, 4 by default.
- `LINE_W`, 256: line width in bits (8 words, 32 bytes); the byte offset is addr[4:0].
- `clk_i` input 1: single clock, rising-edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `cpu_req_i` input 1: CPU access valid this cycle (MemRead or MemWrite).
- `cpu_we_i` input 1: 1 = store, 0 = load.
- `cpu_addr_i` input 32: byte address, word-aligned.
- `cpu_data_i` input 32: store data.
- `cpu_data_o` output 32: load data, valid when `cpu_req_i & !cpu_stall_o`.
- `cpu_stall_o` output 1: freeze the pipeline; the CPU holds all `cpu_*` inputs stable while this is high.
- `mem_req_o` output 1: memory request, held until acknowledged.
- `mem_we_o` output 1: 1 = line write-back, 0 = line read.
- `mem_addr_o` output 32: line-aligned address; bits [4:0] are 0.
- `mem_data_o` output 256: write-back line data.
- `mem_data_i` input 256: refill line data, sampled on the `mem_ack_i` cycle.
- `mem_ack_i` input 1: one-cycle completion pulse from memory.

## Operation
- **Address split** (defaults):
  - tag = addr[31:9], 23 bits.
  - index = addr[8:5].
  - word = addr[4:2].
- **Per-line storage:** valid bit, dirty bit, tag, and 256-bit data.
- **Hit:** `cpu_req_i` & valid[index] & (tag[index] == addr tag).
- **States:** IDLE, WRITEBACK, REFILL, DONE.
  - **IDLE:**
    - On a hit, loads drive the selected word to `cpu_data_o` combinationally.
    - On a hit, a store writes `cpu_data_i` into that word at the clock edge and sets dirty.
    - On a miss, go to WRITEBACK if the line is valid & dirty, else go to REFILL.
  - **WRITEBACK:**
    - Drive `mem_req_o`=1 and `mem_we_o`=1.
    - `mem_addr_o` = {stored tag, index, 5'b0}; `mem_data_o` = stored line.
    - On `mem_ack_i`, go to REFILL.
  - **REFILL:**
    - Drive `mem_req_o`=1, `mem_we_o`=0, and `mem_addr_o` = {request tag, index, 5'b0}.
    - On `mem_ack_i`, write `mem_data_i` into the line, set valid=1, dirty=0 and tag=request tag, then go to DONE.
  - **DONE:** one cycle, then go to IDLE. The held request is then replayed as a hit; a store completes through the normal hit-write path (write-allocate).
- **Stall:** `cpu_stall_o` = (state != IDLE) | (`cpu_req_i` & !hit).
- **Output defaults:**
  - `cpu_data_o` = 0 when there is no read hit.
  - `mem_addr_o` = 0, `mem_we_o` = 0 and `mem_data_o` = 0 when `mem_req_o`=0.
- **Ignored inputs:**
  - `mem_ack_i` is ignored in IDLE and DONE.
  - `cpu_req_i` is ignored outside IDLE; inputs are held stable there.
- **Reset** (asynchronous, `rst_i`=0):
  - State goes to IDLE, all valid and dirty bits clear, all outputs go to 0 immediately.
  - Dirty data is discarded without write-back, including a reset mid-WRITEBACK or mid-REFILL.
  - Data and tag arrays are not reset.

## Timing
- **Hit:** zero added latency; load data is combinational in the request cycle. A store updates the array at the edge ending that cycle.
- **Clean miss**, request in cycle 0 and ack in cycle k (k ≥ 1):
  - Stall is high in cycles 0..k+1.
  - REFILL runs cycles 1..k and DONE is cycle k+1.
  - The hit is served in cycle k+2 with stall low.
- **Dirty miss:**
  - WRITEBACK runs cycles 1..j (ack at cycle j), then REFILL runs cycles j+1..m, then DONE at m+1.
  - The hit is served at m+2.
- **Handshake:**
  - `mem_req_o` rises at the edge entering WRITEBACK or REFILL.
  - It stays high, with stable address and data, until the ack edge.
  - It drops for at least 0 cycles between WRITEBACK and REFILL: REFILL reasserts it directly with `mem_we_o`=0.
- **Ack timing:** an ack arriving in the first cycle of a state is legal and valid.

## Test plan
- **Reset:**
  - Stimulus: `rst_i`=0 for 2 cycles with random inputs.
  - Required: all outputs 0; then a load from 0x0000_0024 misses (stall=1).
- **Clean read miss:**
  - Stimulus: load 0x0000_0024 with memory ack after 3 cycles, line data word1 = 0xDEADBEEF.
  - Required: `mem_addr_o`=0x0000_0020 and `mem_we_o`=0; stall high for 5 cycles; then `cpu_data_o`=0xDEADBEEF with stall low.
- **Store hit:**
  - Stimulus: store 0x12345678 to 0x0000_0024.
  - Required: no stall and no `mem_req_o`; a following load returns 0x12345678.
- **Dirty conflict:**
  - Stimulus: load 0x0000_0224 (same index 1, tag 1).
  - Required:
    - Write-back first, with `mem_addr_o`=0x0000_0020, `mem_we_o`=1 and `mem_data_o` word1=0x12345678.
    - Then refill from 0x0000_0220.
    - Then the load hits.
- **Store miss (write-allocate):**
  - Stimulus: store 0xA5A5A5A5 to 0x0000_0048 on an invalid line.
  - Required: refill from 0x0000_0040; after DONE the word is written and dirty is set; a later conflict writes back 0xA5A5A5A5.
- **Reset mid-refill:**
  - Stimulus: assert `rst_i`=0 during REFILL before the ack.
  - Required: `mem_req_o` and `cpu_stall_o` fall immediately; a late ack is ignored; the line is invalid afterwards.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller between the
// CPU MEM stage and a line-wide external memory with a req/ack handshake.
module dcache_ctrl #(
    parameter int SETS   = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WSEL_W = $clog2(LINE_W / 32);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    state_e state_r;
    state_e state_nxt_s;

    logic [SETS-1:0]   valid_r;
    logic [SETS-1:0]   dirty_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [LINE_W-1:0] data_r [SETS];

    logic [TAG_W-1:0]    req_tag_s;
    logic [IDX_W-1:0]    idx_s;
    logic [WSEL_W-1:0]   word_s;
    logic [WSEL_W+4:0]   word_bit_s;
    logic [LINE_W-1:0]   line_s;
    logic                hit_s;
    logic                store_hit_s;
    logic                refill_done_s;
    logic                addr_unused_s;

    assign req_tag_s     = cpu_addr_i[31 -: TAG_W];
    assign idx_s         = cpu_addr_i[OFF_W +: IDX_W];
    assign word_s        = cpu_addr_i[2 +: WSEL_W];
    assign word_bit_s    = {word_s, 5'b00000};
    assign addr_unused_s = ^cpu_addr_i[1:0];
    assign line_s        = data_r[idx_s];

    assign hit_s         = cpu_req_i & valid_r[idx_s] & (tag_r[idx_s] == req_tag_s);
    assign store_hit_s   = (state_r == ST_IDLE) & hit_s & cpu_we_i;
    assign refill_done_s = (state_r == ST_REFILL) & mem_ack_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the CPU request is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req_i && !hit_s) begin
                    if (valid_r[idx_s] && dirty_r[idx_s]) begin
                        state_nxt_s = ST_WRITEBACK;
                    end else begin
                        state_nxt_s = ST_REFILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_nxt_s = ST_REFILL;
                end else begin
                    state_nxt_s = ST_WRITEBACK;
                end
            end
            ST_REFILL: begin
                if (mem_ack_i) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_REFILL;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        cpu_data_o  = 32'h0000_0000;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0000_0000;
        mem_data_o  = {LINE_W{1'b0}};
        if (!rst_i) begin
            cpu_stall_o = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_stall_o = cpu_req_i & !hit_s;
                    if (hit_s && !cpu_we_i) begin
                        cpu_data_o = line_s[word_bit_s +: 32];
                    end else begin
                        cpu_data_o = 32'h0000_0000;
                    end
                end
                ST_WRITEBACK: begin
                    cpu_stall_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = {tag_r[idx_s], idx_s, {OFF_W{1'b0}}};
                    mem_data_o  = line_s;
                end
                ST_REFILL: begin
                    cpu_stall_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b0;
                    mem_addr_o  = {req_tag_s, idx_s, {OFF_W{1'b0}}};
                end
                ST_DONE:  cpu_stall_o = 1'b1;
                default:  cpu_stall_o = 1'b0;
            endcase
        end
    end

    // Valid/dirty bits: cleared by reset so dirty data is dropped, not written back.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= {SETS{1'b0}};
            dirty_r <= {SETS{1'b0}};
        end else if (refill_done_s) begin
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
        end else if (store_hit_s) begin
            dirty_r[idx_s] <= 1'b1;
        end else begin
            dirty_r <= dirty_r;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk_i) begin
        if (refill_done_s) begin
            data_r[idx_s] <= mem_data_i;
            tag_r[idx_s]  <= req_tag_s;
        end else if (store_hit_s) begin
            data_r[idx_s][word_bit_s +: 32] <= cpu_data_i;
        end else begin
            tag_r[idx_s] <= tag_r[idx_s];
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed plan steps followed by random
// accesses, compared against a set-level cache model and a line memory model.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    int errors = 0;
    int checks = 0;

    bit           m_valid [16];
    bit           m_dirty [16];
    bit [22:0]    m_tag   [16];
    bit [255:0]   m_data  [16];
    bit [255:0]   mem_m   [bit [31:0]];

    dcache_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_data_i  (cpu_wdata),
        .cpu_data_o  (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [255:0] rand_line();
        bit [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic bit [255:0] get_line(input bit [31:0] a);
        if (!mem_m.exists(a)) mem_m[a] = rand_line();
        return mem_m[a];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stall"}, cpu_stall, 1'b0);
        check({tag, "_mreq"},  mem_req,   1'b0);
        check({tag, "_mwe"},   mem_we,    1'b0);
        check({tag, "_maddr"}, mem_addr,  32'h0);
        check({tag, "_mdata"}, mem_wdata, 256'h0);
        check({tag, "_rdata"}, cpu_rdata, 32'h0);
    endtask

    // One CPU access from the cycle it is presented until it is served.
    // A latency of 0 picks a random ack cycle in 1..4.
    task automatic access(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                          input int lat_wb, input int lat_rf, output bit [31:0] rdata);
        bit [3:0]   idx;
        bit [22:0]  tg;
        bit [2:0]   wd;
        bit [31:0]  laddr;
        bit [255:0] line;
        int         k;
        idx = addr[8:5];
        tg  = addr[31:9];
        wd  = addr[4:2];
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            @(negedge clk);
            check("miss_stall", cpu_stall, 1'b1);
            check("miss_noreq", mem_req, 1'b0);
            @(posedge clk); #1;
            if (m_valid[idx] && m_dirty[idx]) begin
                laddr = {m_tag[idx], idx, 5'b0};
                k = (lat_wb == 0) ? $urandom_range(4, 1) : lat_wb;
                for (int c = 1; c <= k; c++) begin
                    mem_ack = (c == k);
                    mem_rdata = rand_line();
                    @(negedge clk);
                    check("wb_req",   mem_req,   1'b1);
                    check("wb_we",    mem_we,    1'b1);
                    check("wb_addr",  mem_addr,  laddr);
                    check("wb_data",  mem_wdata, m_data[idx]);
                    check("wb_stall", cpu_stall, 1'b1);
                    @(posedge clk); #1;
                end
                mem_ack = 1'b0;
                mem_m[laddr] = m_data[idx];
            end
            laddr = {tg, idx, 5'b0};
            line = get_line(laddr);
            k = (lat_rf == 0) ? $urandom_range(4, 1) : lat_rf;
            for (int c = 1; c <= k; c++) begin
                mem_ack = (c == k);
                mem_rdata = (c == k) ? line : rand_line();
                @(negedge clk);
                check("rf_req",   mem_req,   1'b1);
                check("rf_we",    mem_we,    1'b0);
                check("rf_addr",  mem_addr,  laddr);
                check("rf_data",  mem_wdata, 256'h0);
                check("rf_stall", cpu_stall, 1'b1);
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = line;
            @(negedge clk);
            check("done_stall", cpu_stall, 1'b1);
            check("done_noreq", mem_req, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("hit_stall", cpu_stall, 1'b0);
        check("hit_noreq", mem_req, 1'b0);
        rdata = cpu_rdata;
        if (!we) check("hit_load", cpu_rdata, m_data[idx][wd*32 +: 32]);
        else     check("hit_store_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        if (we) begin
            m_data[idx][wd*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        bit [31:0]  rd;
        bit [255:0] l;
        bit [31:0]  a;

        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 23'h0; m_data[i] = 256'h0;
        end
        l = rand_line();
        l[63:32] = 32'hDEAD_BEEF;
        mem_m[32'h0000_0020] = l;

        // Reset with random inputs: every output must read zero.
        rst_i = 1'b0; mem_ack = 1'b0; mem_rdata = 256'h0;
        for (int i = 0; i < 2; i++) begin
            cpu_req = 1'($urandom); cpu_we = 1'($urandom);
            cpu_addr = {$urandom} & 32'hFFFF_FFFC; cpu_wdata = $urandom;
            mem_ack = 1'($urandom); mem_rdata = rand_line();
            @(negedge clk);
            check_idle_outputs("reset");
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; cpu_we = 1'b0; mem_ack = 1'b0;
        #2 rst_i = 1'b1;
        @(posedge clk); #1;

        // Clean read miss with ack in the third refill cycle.
        access(1'b0, 32'h0000_0024, 32'h0, 1, 3, rd);
        check("clean_miss_data", rd, 32'hDEAD_BEEF);

        // Store hit then load back.
        access(1'b1, 32'h0000_0024, 32'h1234_5678, 0, 0, rd);
        access(1'b0, 32'h0000_0024, 32'h0, 0, 0, rd);
        check("store_hit_readback", rd, 32'h1234_5678);

        // Dirty conflict on index 1: write-back of 0x20 then refill of 0x220.
        check("dirty_model_wb_word", m_data[1][63:32], 32'h1234_5678);
        access(1'b0, 32'h0000_0224, 32'h0, 2, 1, rd);
        check("dirty_wb_mem_word", mem_m[32'h0000_0020][63:32], 32'h1234_5678);

        // Store miss on an invalid line, then a conflict forces it back out.
        access(1'b1, 32'h0000_0048, 32'hA5A5_A5A5, 0, 2, rd);
        access(1'b0, 32'h0000_0248, 32'h0, 1, 1, rd);
        check("alloc_wb_word", mem_m[32'h0000_0040][95:64], 32'hA5A5_A5A5);

        // Reset in the middle of a refill, followed by late acks.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_01E4;
        @(negedge clk);
        check("rr_miss_stall", cpu_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rr_refill_req", mem_req, 1'b1);
        check("rr_refill_addr", mem_addr, 32'h0000_01E0);
        #2 rst_i = 1'b0;
        #1 check_idle_outputs("rr_async");
        cpu_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = rand_line();
        @(posedge clk); #1;
        mem_ack = 1'b0; rst_i = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = rand_line();
        @(negedge clk);
        check_idle_outputs("rr_late_ack");
        @(posedge clk); #1;
        mem_ack = 1'b0;
        access(1'b0, 32'h0000_01E4, 32'h0, 0, 0, rd);
        access(1'b0, 32'h0000_0248, 32'h0, 0, 0, rd);

        // Random accesses over a few tags per index to mix hits, clean and dirty misses.
        for (int n = 0; n < 80; n++) begin
            a = {21'h0, 2'($urandom_range(3, 0)), 4'($urandom), 3'($urandom), 2'b00};
            access(1'($urandom), a, $urandom, 0, 0, rd);
            if ($urandom_range(3, 0) == 0) begin
                @(negedge clk);
                check_idle_outputs("rand_idle");
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
